// File: rtl/sprite_motion_sched_pkg.sv
// Shared types and constants for the sprite motion scheduler.
package sprite_motion_sched_pkg;

  // Movement limits for the stock 1280x720 demo with a 40-pixel border and 40-pixel blocks.
  localparam logic [10:0] X_MIN = 11'd40;
  localparam logic [10:0] X_MAX = 11'd1200;
  localparam logic [10:0] Y_MIN = 11'd40;
  localparam logic [10:0] Y_MAX = 11'd640;

  // Config field codes (cfg_addr[1:0]).
  localparam logic [1:0] CFG_CTRL = 2'd0;
  localparam logic [1:0] CFG_X    = 2'd1;
  localparam logic [1:0] CFG_Y    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hdir;  // 1 = moving right
    logic        vdir;  // 1 = moving down
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic        en;
  } sprite_t;

  // Saturate a coordinate into [lo, hi].
  function automatic logic [10:0] clamp11(input logic [10:0] v,
                                          input logic [10:0] lo,
                                          input logic [10:0] hi);
    logic [10:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion_sched_if.sv
// Config write port: a write is accepted on any edge where cfg_we && cfg_ready.
interface sprite_motion_sched_if;
  logic        cfg_we;
  logic [3:0]  cfg_addr;   // {sprite[1:0], field[1:0]}
  logic [15:0] cfg_wdata;
  logic        cfg_ready;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_ready);
endinterface

// File: rtl/sprite_motion_sched_axis_bounce.sv
// Single-axis step with bounce: moves a coordinate by step in its direction,
// saturating at the limits and reversing direction when a limit is reached.
module sprite_motion_sched_axis_bounce #(
  parameter int LO = 40,
  parameter int HI = 1200
) (
  input  logic [10:0] pos_i,
  input  logic        dir_i,
  input  logic [3:0]  step_i,
  output logic [10:0] pos_o,
  output logic        dir_o
);
  localparam logic [11:0] LO12 = 12'(LO);
  localparam logic [11:0] HI12 = 12'(HI);

  logic [11:0] pos12_s;
  logic [11:0] sum_s;
  logic [11:0] low_s;

  // Next position/direction; 12-bit sums keep the comparisons free of wrap.
  always_comb begin
    pos12_s = {1'b0, pos_i};
    sum_s   = pos12_s + {8'd0, step_i};
    low_s   = LO12 + {8'd0, step_i};
    pos_o   = pos_i;
    dir_o   = dir_i;
    if (dir_i) begin
      if (sum_s >= HI12) begin
        pos_o = HI12[10:0];
        dir_o = 1'b0;
      end else begin
        pos_o = sum_s[10:0];
        dir_o = 1'b1;
      end
    end else begin
      if (pos12_s <= low_s) begin
        pos_o = LO12[10:0];
        dir_o = 1'b1;
      end else begin
        pos_o = pos_i - {7'd0, step_i};
        dir_o = 1'b0;
      end
    end
  end
endmodule

// File: rtl/sprite_motion_sched.sv
// Frame-synchronous sprite motion scheduler: updates one sprite per cycle
// after the last active line and publishes all coordinates at once.
module sprite_motion_sched
  import sprite_motion_sched_pkg::*;
#(
  parameter int N_SPR     = 4,
  parameter int H_DISP    = 1280,
  parameter int V_DISP    = 720,
  parameter int SIDE_W    = 40,
  parameter int BLOCK_W   = 40,
  parameter int FRAME_DIV = 1
) (
  input  logic                   pixel_clk,
  input  logic                   sys_rst_n,
  input  logic                   de,
  input  logic [10:0]            pixel_ypos,
  sprite_motion_sched_if.slave   cfg,
  output logic [11*N_SPR-1:0]    spr_x,
  output logic [11*N_SPR-1:0]    spr_y,
  output logic [N_SPR-1:0]       spr_en,
  output logic                   upd_done
);
  localparam int          IDX_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam logic [10:0] X_LO  = 11'(SIDE_W);
  localparam logic [10:0] X_HI  = 11'(H_DISP - SIDE_W - BLOCK_W);
  localparam logic [10:0] Y_LO  = 11'(SIDE_W);
  localparam logic [10:0] Y_HI  = 11'(V_DISP - SIDE_W - BLOCK_W);
  localparam logic [10:0] LAST_LINE = 11'(V_DISP - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(FRAME_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SPR - 1);

  logic                 de_q;
  logic                 frame_end_q;
  logic                 frame_end_s;
  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           div_q;
  logic                 cfg_ready_q;
  logic                 upd_done_q;
  sprite_t              shadow_q [N_SPR];
  logic [11*N_SPR-1:0]  spr_x_q;
  logic [11*N_SPR-1:0]  spr_y_q;
  logic [N_SPR-1:0]     spr_en_q;

  sprite_t              cur_s;
  logic [10:0]          nx_s;
  logic [10:0]          ny_s;
  logic                 nh_s;
  logic                 nv_s;
  logic [1:0]           cfg_spr_s;
  logic [IDX_W-1:0]     cfg_idx_s;
  logic                 cfg_hit_s;
  logic                 cfg_unused_s;

  assign frame_end_s  = de_q && !de && (pixel_ypos == LAST_LINE);
  assign cur_s        = shadow_q[idx_q];
  assign cfg_spr_s    = cfg.cfg_addr[3:2];
  assign cfg_idx_s    = cfg_spr_s[IDX_W-1:0];
  assign cfg_hit_s    = cfg.cfg_we && cfg_ready_q && ({30'd0, cfg_spr_s} < 32'(N_SPR));
  assign cfg_unused_s = &{1'b0, cfg.cfg_wdata[15:11]};

  sprite_motion_sched_axis_bounce #(.LO(SIDE_W), .HI(H_DISP - SIDE_W - BLOCK_W)) u_axis_x (
    .pos_i (cur_s.x),
    .dir_i (cur_s.hdir),
    .step_i(cur_s.dx),
    .pos_o (nx_s),
    .dir_o (nh_s)
  );

  sprite_motion_sched_axis_bounce #(.LO(SIDE_W), .HI(V_DISP - SIDE_W - BLOCK_W)) u_axis_y (
    .pos_i (cur_s.y),
    .dir_i (cur_s.vdir),
    .step_i(cur_s.dy),
    .pos_o (ny_s),
    .dir_o (nv_s)
  );

  // Detect the falling edge of de on the last active line, registered once.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_q        <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      de_q        <= de;
      frame_end_q <= frame_end_s;
    end
  end

  // Scheduler FSM: frame divider, config writes, per-sprite update and atomic publish.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      div_q       <= 8'd0;
      cfg_ready_q <= 1'b1;
      upd_done_q  <= 1'b0;
      for (int i = 0; i < N_SPR; i++) begin
        shadow_q[i] <= '{x: X_LO, y: Y_LO, hdir: 1'b1, vdir: 1'b1,
                         dx: 4'd1, dy: 4'd1, en: (i == 0)};
        spr_x_q[11*i +: 11] <= X_LO;
        spr_y_q[11*i +: 11] <= Y_LO;
        spr_en_q[i]         <= (i == 0);
      end
    end else begin
      upd_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cfg_ready_q <= 1'b1;
          if (cfg_hit_s) begin
            case (cfg.cfg_addr[1:0])
              CFG_CTRL: begin
                shadow_q[cfg_idx_s].en <= cfg.cfg_wdata[8];
                shadow_q[cfg_idx_s].dx <= cfg.cfg_wdata[7:4];
                shadow_q[cfg_idx_s].dy <= cfg.cfg_wdata[3:0];
              end
              CFG_X: begin
                shadow_q[cfg_idx_s].x    <= clamp11(cfg.cfg_wdata[10:0], X_LO, X_HI);
                shadow_q[cfg_idx_s].hdir <= 1'b1;
              end
              CFG_Y: begin
                shadow_q[cfg_idx_s].y    <= clamp11(cfg.cfg_wdata[10:0], Y_LO, Y_HI);
                shadow_q[cfg_idx_s].vdir <= 1'b1;
              end
              default: begin
                // reserved field: write has no effect
              end
            endcase
          end
          if (frame_end_q) begin
            if (div_q == DIV_LAST) begin
              div_q       <= 8'd0;
              idx_q       <= '0;
              state_q     <= ST_UPDATE;
              cfg_ready_q <= 1'b0;
            end else begin
              div_q <= div_q + 8'd1;
            end
          end
        end
        ST_UPDATE: begin
          cfg_ready_q <= 1'b0;
          if (cur_s.en) begin
            shadow_q[idx_q].x    <= nx_s;
            shadow_q[idx_q].hdir <= nh_s;
            shadow_q[idx_q].y    <= ny_s;
            shadow_q[idx_q].vdir <= nv_s;
          end
          if (idx_q == IDX_LAST) begin
            state_q <= ST_PUBLISH;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_PUBLISH: begin
          for (int i = 0; i < N_SPR; i++) begin
            spr_x_q[11*i +: 11] <= shadow_q[i].x;
            spr_y_q[11*i +: 11] <= shadow_q[i].y;
            spr_en_q[i]         <= shadow_q[i].en;
          end
          upd_done_q  <= 1'b1;
          cfg_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign spr_x         = spr_x_q;
  assign spr_y         = spr_y_q;
  assign spr_en        = spr_en_q;
  assign upd_done      = upd_done_q;

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Scoreboard bench for sprite_motion_sched: stimulus pushes expected publishes,
// a negedge monitor pops and compares on every upd_done pulse.
module tb_sprite_motion_sched;
  localparam int N_SPR = 4;
  localparam int LAT   = N_SPR + 2;

  typedef struct {
    logic [43:0] x;
    logic [43:0] y;
    logic [3:0]  en;
    int          cyc;
  } exp_t;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        de        = 1'b0;
  logic        de2       = 1'b0;
  logic [10:0] pixel_ypos = 11'd0;
  logic [43:0] spr_x, spr_y, spr_x2, spr_y2;
  logic [3:0]  spr_en, spr_en2;
  logic        upd_done, upd_done2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pub2     = 0;
  int low_run  = 0;
  exp_t exp_q[$];

  sprite_motion_sched_if cfg1();
  sprite_motion_sched_if cfg2();

  sprite_motion_sched #(.N_SPR(N_SPR), .FRAME_DIV(1)) dut (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .de(de), .pixel_ypos(pixel_ypos),
    .cfg(cfg1.slave), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .upd_done(upd_done)
  );

  sprite_motion_sched #(.N_SPR(N_SPR), .FRAME_DIV(3)) dut_div3 (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .de(de2), .pixel_ypos(pixel_ypos),
    .cfg(cfg2.slave), .spr_x(spr_x2), .spr_y(spr_y2), .spr_en(spr_en2), .upd_done(upd_done2)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  function automatic logic [43:0] p4(input int a, input int b, input int c, input int d);
    return {11'(d), 11'(c), 11'(b), 11'(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  // Scoreboard monitor for the FRAME_DIV=1 instance.
  always @(negedge pixel_clk) begin
    exp_t e;
    if (upd_done) begin
      if (exp_q.size() == 0) begin
        chk("upd_done_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("spr_x", 64'(spr_x), 64'(e.x));
        chk("spr_y", 64'(spr_y), 64'(e.y));
        chk("spr_en", 64'(spr_en), 64'(e.en));
      end
    end
  end

  // cfg_ready must stay low for exactly N_SPR+1 cycles per update pass.
  always @(negedge pixel_clk) begin
    if (!sys_rst_n) begin
      low_run = 0;
    end else if (!cfg1.cfg_ready) begin
      low_run++;
    end else if (low_run != 0) begin
      chk("cfg_ready_low_cycles", 64'(low_run), 64'(N_SPR + 1));
      low_run = 0;
    end
  end

  // Publish counter for the FRAME_DIV=3 instance.
  always @(negedge pixel_clk) begin
    if (upd_done2) pub2++;
  end

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    logic r;
    bit   done;
    done = 1'b0;
    cfg1.cfg_we = 1'b1; cfg1.cfg_addr = a; cfg1.cfg_wdata = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge pixel_clk); r = cfg1.cfg_ready;
      @(posedge pixel_clk);
      if (r) done = 1'b1;
    end
    #1 cfg1.cfg_we = 1'b0;
    if (!done) chk("cfg_write_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_frame(input bit push_exp, input logic [43:0] ex, input logic [43:0] ey,
                          input logic [3:0] een, input bit sel2,
                          input bit hold_wr, input logic [3:0] a, input logic [15:0] d);
    bit seen;
    pixel_ypos = 11'd719;
    if (sel2) de2 = 1'b1; else de = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    if (sel2) de2 = 1'b0; else de = 1'b0;
    if (push_exp) exp_q.push_back('{x: ex, y: ey, en: een, cyc: cyc + 1 + LAT});
    @(posedge pixel_clk); #1;
    pixel_ypos = 11'd0;
    if (hold_wr) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge pixel_clk);
        if (!cfg1.cfg_ready) seen = 1'b1;
      end
      if (!seen) chk("cfg_ready_never_low", 64'd0, 64'd1);
      @(posedge pixel_clk); #1;
      cfg_write(a, d);
    end
    repeat (10) @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, 64'(spr_x), 64'(p4(40, 40, 40, 40)));
    chk({tag, "_y"}, 64'(spr_y), 64'(p4(40, 40, 40, 40)));
    chk({tag, "_en"}, 64'(spr_en), 64'(4'b0001));
    chk({tag, "_ready"}, 64'(cfg1.cfg_ready), 64'd1);
    chk({tag, "_done"}, 64'(upd_done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    cfg1.cfg_we = 1'b0; cfg1.cfg_addr = 4'd0; cfg1.cfg_wdata = 16'd0;
    cfg2.cfg_we = 1'b0; cfg2.cfg_addr = 4'd0; cfg2.cfg_wdata = 16'd0;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk_reset_state("reset");
    @(posedge pixel_clk); #1;
    sys_rst_n = 1'b1;
    repeat (2) @(posedge pixel_clk);
    #1;

    // Basic step of sprite 0.
    do_frame(1, p4(41, 40, 40, 40), p4(41, 40, 40, 40), 4'b0001, 0, 0, 4'h0, 16'h0);

    // Sprite 1 near the right border, dx=3, dy=0.
    cfg_write(4'h5, 16'd1198);
    cfg_write(4'h4, 16'h0130);
    do_frame(1, p4(42, 1200, 40, 40), p4(42, 40, 40, 40), 4'b0011, 0, 0, 4'h0, 16'h0);
    do_frame(1, p4(43, 1197, 40, 40), p4(43, 40, 40, 40), 4'b0011, 0, 0, 4'h0, 16'h0);

    // Clamped placement of sprite 2 plus a reserved-field write to sprite 3.
    cfg_write(4'h9, 16'd2000);
    cfg_write(4'hA, 16'd5);
    cfg_write(4'hF, 16'hFFFF);
    do_frame(1, p4(44, 1194, 1200, 40), p4(44, 40, 40, 40), 4'b0011, 0, 0, 4'h0, 16'h0);

    // Write held across the update pass lands only after this frame's publish.
    do_frame(1, p4(45, 1191, 1200, 40), p4(45, 40, 40, 40), 4'b0011, 0, 1, 4'hC, 16'h0122);
    do_frame(1, p4(46, 1188, 1200, 42), p4(46, 40, 40, 42), 4'b1011, 0, 0, 4'h0, 16'h0);

    // Sprite 2: dx=0 at the right limit, y bounce at the bottom.
    cfg_write(4'h8, 16'h0104);
    cfg_write(4'hA, 16'd638);
    do_frame(1, p4(47, 1185, 1200, 44), p4(47, 40, 640, 44), 4'b1111, 0, 0, 4'h0, 16'h0);
    do_frame(1, p4(48, 1182, 1200, 46), p4(48, 40, 636, 46), 4'b1111, 0, 0, 4'h0, 16'h0);

    // Reset in the middle of an update pass (idx=2).
    pixel_ypos = 11'd719;
    de = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1 de = 1'b0;
    repeat (4) @(posedge pixel_clk);
    #1;
    pixel_ypos = 11'd0;
    sys_rst_n  = 1'b0;
    @(negedge pixel_clk);
    chk_reset_state("midreset");
    @(posedge pixel_clk); #1;
    sys_rst_n = 1'b1;
    repeat (12) @(posedge pixel_clk);
    #1;
    do_frame(1, p4(41, 40, 40, 40), p4(41, 40, 40, 40), 4'b0001, 0, 0, 4'h0, 16'h0);

    // FRAME_DIV=3 instance: publishes on frames 3 and 6 only.
    for (int f = 1; f <= 6; f++) begin
      do_frame(0, 44'd0, 44'd0, 4'd0, 1, 0, 4'h0, 16'h0);
      chk($sformatf("div3_pubs_f%0d", f), 64'(pub2), 64'(f / 3));
      chk($sformatf("div3_x_f%0d", f), 64'(spr_x2[10:0]), 64'(40 + f / 3));
      chk($sformatf("div3_y_f%0d", f), 64'(spr_y2[10:0]), 64'(40 + f / 3));
    end

    repeat (5) @(posedge pixel_clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
